dm_sync_clr: RTL and testbench
==============================

Name: dm_sync_clr

Overview:
Parametrised word-organised data memory for the MIPS-C datapath, next generation of the core's data memory.
- Takes byte addresses and load/store size, and generates byte enables internally.
- Sign- or zero-extends loads, flags misaligned accesses, and returns load data registered.
- Replaces the single-cycle bulk reset with a sequential hardware clear sweep, signalled by Busy.
- Sits between the MEM-stage address/size decode and the write-back mux.

Parameters:
AW, 13, word-address width; depth = 2**AW words of 32 bits
CLEAR_ON_RESET, 1, 1 = sweep-clear all words after reset; 0 = skip the clear (Busy drops the cycle after reset)

Ports:
Clk  in  1  clock; all logic on the rising edge
Reset  in  1  synchronous, active-high reset
Req  in  1  access request, valid for one cycle
We  in  1  1 = store, 0 = load (qualified by Req)
Addr  in  AW+2  byte address; [AW+1:2] word index, [1:0] byte offset
Size  in  2  00 byte, 01 half, 10 word, 11 illegal
Signed  in  1  load extension: 1 = sign, 0 = zero
Din  in  32  store data, right-justified (byte in [7:0], half in [15:0])
Ready  out  1  1 = request accepted this cycle
Busy  out  1  clear sweep in progress
Dout  out  32  extended load data, valid when Rvalid
Rvalid  out  1  load response pulse
Misalign  out  1  error pulse, aligned in time with the would-be response

Behaviour:
- Clock and reset: Clk and Reset, synchronous active-high; Reset is sampled only at the rising edge of Clk.
- Reset values: Busy=CLEAR_ON_RESET, Ready=~Busy, Rvalid=0, Misalign=0, Dout=0, clear counter=0.
- Reset asserted mid-sweep or mid-access: any pending response is dropped and the sweep restarts at word 0. A store in flight on the reset edge is not written.
- States: CLEAR and RUN.
  - CLEAR: writes 0 to word[cnt] each cycle and increments cnt. After writing word 2**AW-1 (cnt wrap), goes to RUN. Total 2**AW cycles with Busy=1.
  - RUN: Busy=0.
- Ready = state==RUN. Req while Busy is ignored: no write, no Rvalid, no Misalign.
- Alignment rules:
  - Half with Addr[0]=1 is misaligned.
  - Word with Addr[1:0]!=0 is misaligned.
  - Size=11 is always misaligned.
  - A misaligned access performs no memory write.
- Store lane placement:
  - byte: BE = 1<<Addr[1:0]; data replicated {4{Din[7:0]}}.
  - half: BE = Addr[1] ? 1100 : 0011; data {2{Din[15:0]}}.
  - word: BE = 1111.
  - Only enabled byte lanes are written, at the accepting edge.
- Store response: no Rvalid. A misaligned store pulses Misalign one cycle after acceptance.
- Load latency: exactly 1 cycle. Rvalid and Dout are registered at the accepting edge and held for one cycle only.
  - Byte/half lanes are extracted by Addr[1:0] and extended per Signed; word loads ignore Signed.
  - A misaligned load gives Rvalid=1, Misalign=1, Dout=0.
- Back-to-back: one request per cycle, full throughput.
  - A load in the cycle after a store to the same word returns the updated data.
  - Load and store are never in the same cycle (single port).
- When Rvalid=0, Dout holds its last value.
- Out-of-range addresses cannot occur: the address width equals the depth.

Decomposition:
- Shared package dm_pkg:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - state encoding ST_CLEAR, ST_RUN.
- Sub-module dm_lane_align, purely combinational:
  - store side: Size, Addr[1:0], Din -> BE, placed data, misaligned flag;
  - load side: word, Size, Addr[1:0], Signed -> extended result.
  - The top level holds the array, the clear FSM/counter and the response registers.

Test Plan:
- Reset with AW=4, CLEAR_ON_RESET=1 -> Busy=1 for exactly 16 cycles, then Ready=1; a load of every word returns 0x00000000 with Rvalid one cycle after Req.
- Store word 0x8899AABB @0x10, then byte load @0x13 with Signed=1 -> Dout=0xFFFFFF88. Same load with Signed=0 -> 0x00000088. Half load @0x12 with Signed=1 -> 0xFFFF8899.
- Store byte 0x5A @0x11 over the word 0x8899AABB, then word load @0x10 -> 0x88995ABB. Store half 0x1234 @0x12, then word load -> 0x12345ABB.
- Misaligned half store @0x21 and word load @0x22 -> no write (word 0x20 still 0); Misalign pulses 1 cycle after each request; the load gives Rvalid=1, Dout=0.
- Reset asserted at sweep cycle 7, after prior stores -> sweep restarts, Busy=1 for 16 more cycles, all words read 0. Req during Busy -> no Rvalid and no write.
- Alternating store/load to the same word every cycle for 32 cycles -> each load returns the value from the immediately preceding store; Rvalid is asserted on every second cycle.

Source files
------------

// File: rtl/dm_pkg.sv
// dm_pkg: shared encodings for the dm_sync_clr data memory.
//   SZ_BYTE/SZ_HALF/SZ_WORD : access size encodings (2'b11 is illegal)
//   dm_state_e              : clear-sweep / run state encoding
//   dm_size_bytes()         : number of bytes touched by an access size
package dm_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } dm_state_e;

    // Returns 0 for the illegal size so callers can treat it as misaligned.
    function automatic logic [2:0] dm_size_bytes(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            SZ_BYTE: n = 3'd1;
            SZ_HALF: n = 3'd2;
            SZ_WORD: n = 3'd4;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/dm_lane_align.sv
// dm_lane_align: combinational byte-lane steering for a 32-bit word memory.
// Store side:
//   size, offset, din  -> be (byte enables), wdata (replicated data), misalign
// Load side:
//   rword, size, offset, is_signed -> rdata (extracted and extended load data)
// A misaligned or illegal access yields be=0 and rdata=0.
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] din,
    input  logic [31:0] rword,
    input  logic        is_signed,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misalign,
    output logic [31:0] rdata
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Store lane placement and alignment check.
    always_comb begin
        be       = 4'b0000;
        wdata    = din;
        misalign = 1'b1;
        case (size)
            SZ_BYTE: begin
                be       = 4'b0001 << offset;
                wdata    = {4{din[7:0]}};
                misalign = 1'b0;
            end
            SZ_HALF: begin
                be       = offset[1] ? 4'b1100 : 4'b0011;
                wdata    = {2{din[15:0]}};
                misalign = offset[0];
            end
            SZ_WORD: begin
                be       = 4'b1111;
                wdata    = din;
                misalign = (offset != 2'b00);
            end
            default: begin
                misalign = 1'b1;
            end
        endcase
        // A rejected access must never touch memory.
        if (misalign) begin
            be = 4'b0000;
        end
    end

    // Load lane extraction and extension.
    always_comb begin
        byte_sel = rword[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? rword[31:16] : rword[15:0];
        rdata    = 32'h0;
        case (size)
            SZ_BYTE: rdata = is_signed ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
            SZ_HALF: rdata = is_signed ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
            SZ_WORD: rdata = rword;
            default: rdata = 32'h0;
        endcase
        if (misalign) begin
            rdata = 32'h0;
        end
    end

endmodule

// File: rtl/dm_sync_clr.sv
// dm_sync_clr: word-organised data memory with byte/half/word access and a
// sequential hardware clear sweep after reset.
// Ports:
//   Clk, Reset         : clock and synchronous active-high reset
//   Req, We            : one-cycle request; We=1 store, We=0 load
//   Addr               : byte address ([AW+1:2] word index, [1:0] byte offset)
//   Size, Signed       : access size; load sign/zero extension
//   Din                : right-justified store data
//   Ready, Busy        : request accepted / clear sweep in progress
//   Dout, Rvalid       : registered load data and its one-cycle valid pulse
//   Misalign           : error pulse aligned with the would-be response
module dm_sync_clr
    import dm_pkg::*;
#(
    parameter int unsigned AW             = 13,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Req,
    input  logic          We,
    input  logic [AW+1:0] Addr,
    input  logic [1:0]    Size,
    input  logic          Signed,
    input  logic [31:0]   Din,
    output logic          Ready,
    output logic          Busy,
    output logic [31:0]   Dout,
    output logic          Rvalid,
    output logic          Misalign
);

    localparam int unsigned Depth = 2 ** AW;

    logic [31:0] mem [Depth];

    dm_state_e   state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    logic        rvalid_q;
    logic        misalign_q;
    logic [31:0] dout_q;

    logic [AW-1:0] word_idx;
    logic [1:0]    offset;
    logic [31:0]   rword;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic          mis;
    logic [31:0]   rdata;
    logic          accept;

    assign word_idx = Addr[AW+1:2];
    assign offset   = Addr[1:0];
    assign rword    = mem[word_idx];
    assign accept   = Req && (state_q == ST_RUN);

    dm_lane_align u_lane_align (
        .size      (Size),
        .offset    (offset),
        .din       (Din),
        .rword     (rword),
        .is_signed (Signed),
        .be        (be),
        .wdata     (wdata),
        .misalign  (mis),
        .rdata     (rdata)
    );

    // Clear sweep: one word per cycle; leave once the last word is written.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == {AW{1'b1}}) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Memory array: no reset; the sweep provides the cleared contents.
    // Writes are suppressed on a reset edge so an in-flight store is dropped.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            if (state_q == ST_CLEAR) begin
                mem[cnt_q] <= 32'h0;
            end else if (accept && We) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) begin
                        mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    // Response registers; Dout holds between load responses.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rvalid_q   <= 1'b0;
            misalign_q <= 1'b0;
            dout_q     <= 32'h0;
        end else begin
            rvalid_q   <= accept && !We;
            misalign_q <= accept && mis;
            if (accept && !We) begin
                dout_q <= rdata;
            end
        end
    end

    assign Ready    = (state_q == ST_RUN);
    assign Busy     = (state_q == ST_CLEAR);
    assign Rvalid   = rvalid_q;
    assign Misalign = misalign_q;
    assign Dout     = dout_q;

endmodule

// File: tb/tb_dm_sync_clr.sv
// tb_dm_sync_clr: self-checking bench for dm_sync_clr (AW=4, sweep enabled).
// Reference model is a flat little-endian byte array.
module tb_dm_sync_clr;
    import dm_pkg::*;

    localparam int unsigned AW     = 4;
    localparam int unsigned NWORDS = 16;
    localparam int unsigned NBYTES = 64;

    logic          Clk;
    logic          Reset;
    logic          Req;
    logic          We;
    logic [AW+1:0] Addr;
    logic [1:0]    Size;
    logic          Signed;
    logic [31:0]   Din;
    logic          Ready;
    logic          Busy;
    logic [31:0]   Dout;
    logic          Rvalid;
    logic          Misalign;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mbytes [NBYTES];
    logic [31:0] exp_dout;

    typedef struct {
        logic        we;
        logic [5:0]  addr;
        logic [1:0]  sz;
        logic        sgn;
        logic [31:0] din;
        logic        erv;
        logic        emis;
        logic [31:0] edout;
    } vec_t;

    vec_t tbl [15];

    dm_sync_clr #(
        .AW             (AW),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Req      (Req),
        .We       (We),
        .Addr     (Addr),
        .Size     (Size),
        .Signed   (Signed),
        .Din      (Din),
        .Ready    (Ready),
        .Busy     (Busy),
        .Dout     (Dout),
        .Rvalid   (Rvalid),
        .Misalign (Misalign)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    function automatic int nbytes_of(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NBYTES; i++) mbytes[i] = 8'h0;
        exp_dout = 32'h0;
    endtask

    // Applies one access to the byte-array model and returns expected outputs.
    task automatic model_step(input logic we, input logic [5:0] addr, input logic [1:0] sz,
                              input logic sgn, input logic [31:0] din,
                              output logic erv, output logic emis, output logic [31:0] edout);
        int n;
        int a;
        logic [31:0] v;
        n    = nbytes_of(sz);
        a    = int'(addr);
        emis = (n == 0) ? 1'b1 : ((a % n) != 0);
        erv  = !we;
        if (we) begin
            if (!emis) for (int i = 0; i < n; i++) mbytes[a + i] = din[8*i +: 8];
        end else if (emis) begin
            exp_dout = 32'h0;
        end else begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v = v | (32'(mbytes[a + i]) << (8 * i));
            if (sgn && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
            exp_dout = v;
        end
        edout = exp_dout;
    endtask

    task automatic issue_raw(input logic we, input logic [5:0] addr, input logic [1:0] sz,
                             input logic sgn, input logic [31:0] din, input logic erv,
                             input logic emis, input logic [31:0] edout, input string name);
        Req    = 1'b1;
        We     = we;
        Addr   = addr;
        Size   = sz;
        Signed = sgn;
        Din    = din;
        @(posedge Clk);
        #1;
        check({name, " rvalid"}, 32'(Rvalid), 32'(erv));
        check({name, " misalign"}, 32'(Misalign), 32'(emis));
        check({name, " dout"}, Dout, edout);
    endtask

    task automatic op(input logic we, input logic [5:0] addr, input logic [1:0] sz,
                      input logic sgn, input logic [31:0] din, input string name);
        logic erv;
        logic emis;
        logic [31:0] edout;
        model_step(we, addr, sz, sgn, din, erv, emis, edout);
        issue_raw(we, addr, sz, sgn, din, erv, emis, edout, name);
    endtask

    task automatic idle();
        Req = 1'b0;
        We  = 1'b0;
        @(posedge Clk);
        #1;
        check("idle rvalid", 32'(Rvalid), 32'h0);
        check("idle misalign", 32'(Misalign), 32'h0);
        check("idle dout hold", Dout, exp_dout);
    endtask

    // Counts cycles until Busy drops; optionally issues requests mid-sweep.
    task automatic wait_sweep(input bit poke, output int n);
        n = 0;
        do begin
            Req    = poke && (n == 10 || n == 12);
            We     = (n == 10);
            Addr   = (n == 10) ? 6'h00 : 6'h01;
            Size   = SZ_WORD;
            Signed = 1'b0;
            Din    = 32'hDEADBEEF;
            @(posedge Clk);
            #1;
            n++;
            if (Req) begin
                check("busy req rvalid", 32'(Rvalid), 32'h0);
                check("busy req misalign", 32'(Misalign), 32'h0);
            end
        end while (Busy && n < 100);
        Req = 1'b0;
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL sweep bound: busy still %0d after %0d cycles, required 0", Busy, n);
        end
    endtask

    initial begin
        int n;
        logic d_erv;
        logic d_emis;
        logic [31:0] d_dout;
        logic [31:0] d;

        Reset  = 1'b1;
        Req    = 1'b0;
        We     = 1'b0;
        Addr   = '0;
        Size   = 2'b00;
        Signed = 1'b0;
        Din    = 32'h0;
        model_clear();

        @(posedge Clk);
        @(posedge Clk);
        #1;
        check("reset busy", 32'(Busy), 32'h1);
        check("reset ready", 32'(Ready), 32'h0);
        check("reset rvalid", 32'(Rvalid), 32'h0);
        check("reset misalign", 32'(Misalign), 32'h0);
        check("reset dout", Dout, 32'h0);
        Reset = 1'b0;

        wait_sweep(1'b0, n);
        check("sweep length", 32'(n), 32'd16);
        check("ready after sweep", 32'(Ready), 32'h1);

        for (int w = 0; w < NWORDS; w++) op(1'b0, 6'(w * 4), SZ_WORD, 1'b0, 32'h0, "init load");
        idle();

        tbl[0]  = '{1'b1, 6'h10, SZ_WORD, 1'b0, 32'h8899AABB, 1'b0, 1'b0, 32'h00000000};
        tbl[1]  = '{1'b0, 6'h13, SZ_BYTE, 1'b1, 32'h0,        1'b1, 1'b0, 32'hFFFFFF88};
        tbl[2]  = '{1'b0, 6'h13, SZ_BYTE, 1'b0, 32'h0,        1'b1, 1'b0, 32'h00000088};
        tbl[3]  = '{1'b0, 6'h12, SZ_HALF, 1'b1, 32'h0,        1'b1, 1'b0, 32'hFFFF8899};
        tbl[4]  = '{1'b1, 6'h11, SZ_BYTE, 1'b0, 32'h0000005A, 1'b0, 1'b0, 32'hFFFF8899};
        tbl[5]  = '{1'b0, 6'h10, SZ_WORD, 1'b0, 32'h0,        1'b1, 1'b0, 32'h88995ABB};
        tbl[6]  = '{1'b1, 6'h12, SZ_HALF, 1'b0, 32'h00001234, 1'b0, 1'b0, 32'h88995ABB};
        tbl[7]  = '{1'b0, 6'h10, SZ_WORD, 1'b1, 32'h0,        1'b1, 1'b0, 32'h12345ABB};
        tbl[8]  = '{1'b1, 6'h21, SZ_HALF, 1'b0, 32'h0000CAFE, 1'b0, 1'b1, 32'h12345ABB};
        tbl[9]  = '{1'b0, 6'h22, SZ_WORD, 1'b0, 32'h0,        1'b1, 1'b1, 32'h00000000};
        tbl[10] = '{1'b0, 6'h20, SZ_WORD, 1'b0, 32'h0,        1'b1, 1'b0, 32'h00000000};
        tbl[11] = '{1'b0, 6'h00, 2'b11,   1'b1, 32'h0,        1'b1, 1'b1, 32'h00000000};
        tbl[12] = '{1'b0, 6'h10, SZ_HALF, 1'b1, 32'h0,        1'b1, 1'b0, 32'h00005ABB};
        tbl[13] = '{1'b0, 6'h10, SZ_BYTE, 1'b1, 32'h0,        1'b1, 1'b0, 32'hFFFFFFBB};
        tbl[14] = '{1'b0, 6'h11, SZ_BYTE, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0000005A};

        for (int i = 0; i < 15; i++) begin
            model_step(tbl[i].we, tbl[i].addr, tbl[i].sz, tbl[i].sgn, tbl[i].din,
                       d_erv, d_emis, d_dout);
            issue_raw(tbl[i].we, tbl[i].addr, tbl[i].sz, tbl[i].sgn, tbl[i].din,
                      tbl[i].erv, tbl[i].emis, tbl[i].edout, $sformatf("vec%0d", i));
        end
        idle();

        repeat (300) begin
            op(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), $urandom, "random");
        end
        idle();

        for (int k = 0; k < 16; k++) begin
            d = $urandom;
            op(1'b1, 6'h30, SZ_WORD, 1'b0, d, "alt store");
            op(1'b0, 6'h30, SZ_WORD, 1'b0, 32'h0, "alt load");
        end
        idle();

        // Reset with a store in flight, then again at sweep cycle 7.
        Reset = 1'b1;
        Req   = 1'b1;
        We    = 1'b1;
        Addr  = 6'h3C;
        Size  = SZ_WORD;
        Din   = 32'hFFFFFFFF;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        Req   = 1'b0;
        model_clear();
        check("rst2 busy", 32'(Busy), 32'h1);
        check("rst2 dout", Dout, 32'h0);
        repeat (7) begin
            Req  = 1'b1;
            We   = 1'b0;
            Addr = 6'h04;
            Size = SZ_WORD;
            @(posedge Clk);
            #1;
            check("partial sweep rvalid", 32'(Rvalid), 32'h0);
            check("partial sweep busy", 32'(Busy), 32'h1);
        end
        Req   = 1'b0;
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        check("mid-sweep reset busy", 32'(Busy), 32'h1);
        wait_sweep(1'b1, n);
        check("restarted sweep length", 32'(n), 32'd16);
        for (int w = 0; w < NWORDS; w++) op(1'b0, 6'(w * 4), SZ_WORD, 1'b0, 32'h0, "post-clear load");
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
